bsg_timeslice_arbiter: RTL and testbench

- Round-robin arbiter that shares one resource among els_p requesters.
- Each winner holds the grant for a programmable time slice. The slice length is measured by an internal dynamic-limit slice counter.
- The grant ends on slice expiry or when the holder drops its request.
- Sits in front of shared datapaths (memory port, network link) where a requester must not starve the others.

---
 rtl/bsg_timeslice_pkg.sv | 33 +++
 rtl/bsg_slice_counter.sv | 47 ++++
 rtl/bsg_timeslice_arbiter.sv | 148 ++++++++++++++
 tb/tb_bsg_timeslice_arbiter.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/bsg_timeslice_pkg.sv
// bsg_timeslice_pkg
//   Shared definitions for the time-slice arbiter:
//     state_e  : arbiter state (IDLE / GRANT)
//     rr_pick  : rotate-then-priority-encode round-robin search
package bsg_timeslice_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  // Widest request vector rr_pick accepts; callers zero-extend into it.
  localparam int rr_max_els_lp = 64;

  // Search reqs starting at (last+1) mod els, wrapping back to last.
  // Returns the first set index. If nothing is set, returns last; callers
  // qualify the result with an any-request term.
  // The loop walks offsets from far to near so that the nearest set bit is
  // the final assignment, which keeps the logic a plain priority chain.
  function automatic int rr_pick(input logic [rr_max_els_lp-1:0] reqs,
                                 input int els,
                                 input int last);
    int pick;
    int idx;
    pick = last;
    for (int i = els; i >= 1; i--) begin
      idx = (last + i) % els;
      if (reqs[idx]) pick = idx;
    end
    return pick;
  endfunction

endpackage

// File: rtl/bsg_slice_counter.sv
// bsg_slice_counter
//   Dynamic-limit slice timer. Latches a quantum at slice start and counts
//   enabled cycles until the quantum is reached.
// Ports:
//   clk_i     clock
//   reset_i   synchronous active-high reset (count=0, quantum=1)
//   en_i      count this cycle (already gated by the caller)
//   load_i    start a fresh slice: count=0, quantum=max(limit_i,1)
//   clear_i   return count to 0 without touching the quantum
//   limit_i   slice length, sampled only on load_i
//   expire_o  combinational: this enabled cycle is the last of the slice
module bsg_slice_counter #(
  parameter int width_p = 16
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               en_i,
  input  logic               load_i,
  input  logic               clear_i,
  input  logic [width_p-1:0] limit_i,
  output logic               expire_o
);

  logic [width_p-1:0] count_r;
  logic [width_p-1:0] quantum_r;

  // The quantum is at most 2^width_p-1, so count_r+1 reaches it before
  // count_r could ever wrap.
  assign expire_o = en_i && ((count_r + width_p'(1)) == quantum_r);

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      count_r   <= '0;
      quantum_r <= width_p'(1);
    end else if (load_i) begin
      count_r   <= '0;
      quantum_r <= (limit_i == '0) ? width_p'(1) : limit_i;
    end else if (clear_i) begin
      count_r   <= '0;
    end else if (en_i && !expire_o) begin
      count_r   <= count_r + width_p'(1);
    end
  end

endmodule

// File: rtl/bsg_timeslice_arbiter.sv
// bsg_timeslice_arbiter
//   Round-robin arbiter sharing one resource among els_p requesters. Each
//   winner holds its grant for a programmable number of enabled cycles, or
//   until it drops its request, then the next requester is picked with no
//   idle bubble.
// Ports:
//   clk_i            clock
//   reset_i          synchronous active-high reset
//   reqs_i           per-requester level request
//   limit_i          slice length in enabled cycles (0 acts as 1), sampled
//                    at grant start only
//   en_i             slice time advances only while high
//   grants_o         registered one-hot grant (or all zero)
//   grant_id_o       index of current / last grantee
//   busy_o           a grant is active
//   expired_o        one-cycle pulse: the current slice expires this cycle
//   preempt_count_o  (BSG_TIMESLICE_ARB_PREEMPT_STATS_EN only) saturating
//                    count of expiries that handed the grant to a waiter
// Optional feature macro: BSG_TIMESLICE_ARB_PREEMPT_STATS_EN
module bsg_timeslice_arbiter
  import bsg_timeslice_pkg::*;
#(
  parameter  int els_p     = 4,
  parameter  int width_p   = 16,
  localparam int lg_els_lp = $clog2(els_p)
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic [els_p-1:0]     reqs_i,
  input  logic [width_p-1:0]   limit_i,
  input  logic                 en_i,
  output logic [els_p-1:0]     grants_o,
  output logic [lg_els_lp-1:0] grant_id_o,
  output logic                 busy_o,
  output logic                 expired_o
`ifdef BSG_TIMESLICE_ARB_PREEMPT_STATS_EN
  ,
  output logic [width_p-1:0]   preempt_count_o
`endif
);

  state_e                 state_r;
  logic [els_p-1:0]       grants_r;
  logic [lg_els_lp-1:0]   grant_id_r;

  logic                   busy;
  logic                   any_req;
  logic                   holder_req;
  logic                   release_w;
  logic                   slice_en;
  logic                   expire_w;
  logic                   arb_w;
  logic                   load_w;
  logic                   clear_w;
  logic [lg_els_lp-1:0]   pick_id;
  logic [els_p-1:0]       pick_onehot;

  assign busy       = (state_r == GRANT);
  assign any_req    = |reqs_i;
  assign holder_req = reqs_i[grant_id_r];

  // Release wins over expiry: a holder that drops its request never
  // produces an expiry, because slice time only advances while it requests.
  assign release_w  = busy && !holder_req;
  assign slice_en   = busy && holder_req && en_i;

  // Arbitrate whenever idle or the current slice ends this cycle. The holder
  // is not excluded, so a lone requester is simply re-granted.
  assign arb_w   = !busy || release_w || expire_w;
  assign load_w  = arb_w && any_req;
  assign clear_w = arb_w && !any_req;

  assign pick_id     = lg_els_lp'(rr_pick(rr_max_els_lp'(reqs_i), els_p,
                                          int'(grant_id_r)));
  assign pick_onehot = {{(els_p-1){1'b0}}, 1'b1} << pick_id;

  bsg_slice_counter #(
    .width_p (width_p)
  ) slice_counter (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .en_i     (slice_en),
    .load_i   (load_w),
    .clear_i  (clear_w),
    .limit_i  (limit_i),
    .expire_o (expire_w)
  );

  // Reset pre-empts the slice without announcing an expiry.
  assign expired_o  = expire_w && !reset_i;
  assign grants_o   = grants_r;
  assign grant_id_o = grant_id_r;
  assign busy_o     = busy;

  // NOTE: every control register has an explicit reset value; grant_id
  // starts at els_p-1 so that requester 0 is searched first.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r    <= IDLE;
      grants_r   <= '0;
      grant_id_r <= lg_els_lp'(els_p - 1);
    end else begin
      case (state_r)
        IDLE: begin
          if (any_req) begin
            state_r    <= GRANT;
            grants_r   <= pick_onehot;
            grant_id_r <= pick_id;
          end
        end
        GRANT: begin
          if (release_w || expire_w) begin
            if (any_req) begin
              grants_r   <= pick_onehot;
              grant_id_r <= pick_id;
            end else begin
              state_r    <= IDLE;
              grants_r   <= '0;
            end
          end
        end
        default: begin
          state_r  <= IDLE;
          grants_r <= '0;
        end
      endcase
    end
  end

`ifdef BSG_TIMESLICE_ARB_PREEMPT_STATS_EN
  logic               others_waiting;
  logic [width_p-1:0] preempt_count_r;

  // An expiry counts only when someone other than the holder is waiting,
  // i.e. the grant actually moves because time ran out.
  assign others_waiting  = |(reqs_i & ~grants_r);
  assign preempt_count_o = preempt_count_r;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      preempt_count_r <= '0;
    end else if (expire_w && others_waiting && (preempt_count_r != '1)) begin
      preempt_count_r <= preempt_count_r + width_p'(1);
    end
  end
`endif

endmodule

// File: tb/tb_bsg_timeslice_arbiter.sv
// tb_bsg_timeslice_arbiter
//   Self-checking bench for bsg_timeslice_arbiter (els_p=4, width_p=16).
//   A reference model tracks holder / remaining enabled cycles of the slice
//   and is compared against the DUT every cycle, plus directed checks for
//   the documented scenarios and a randomized phase.
//   With BSG_TIMESLICE_ARB_PREEMPT_STATS_EN defined, preempt_count_o is
//   also checked.
module tb_bsg_timeslice_arbiter;

  localparam int els_p   = 4;
  localparam int width_p = 16;

  logic                 clk_i = 1'b0;
  logic                 reset_i = 1'b1;
  logic [els_p-1:0]     reqs_i = '0;
  logic [width_p-1:0]   limit_i = '0;
  logic                 en_i = 1'b0;
  logic [els_p-1:0]     grants_o;
  logic [1:0]           grant_id_o;
  logic                 busy_o;
  logic                 expired_o;
`ifdef BSG_TIMESLICE_ARB_PREEMPT_STATS_EN
  logic [width_p-1:0]   preempt_count_o;
`endif

  bsg_timeslice_arbiter #(
    .els_p   (els_p),
    .width_p (width_p)
  ) dut (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .reqs_i     (reqs_i),
    .limit_i    (limit_i),
    .en_i       (en_i),
    .grants_o   (grants_o),
    .grant_id_o (grant_id_o),
    .busy_o     (busy_o),
    .expired_o  (expired_o)
`ifdef BSG_TIMESLICE_ARB_PREEMPT_STATS_EN
    ,
    .preempt_count_o (preempt_count_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: who holds the grant and how many enabled cycles of
  // its slice remain.
  bit m_busy = 1'b0;
  int m_id   = els_p - 1;
  int m_left = 1;
  int m_pc   = 0;
  int n_expired_seen = 0;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic int model_pick(input logic [els_p-1:0] q, input int last);
    for (int i = 1; i <= els_p; i++) begin
      if (q[(last + i) % els_p]) return (last + i) % els_p;
    end
    return last;
  endfunction

  // One clock cycle: drive inputs, check the combinational expiry pulse,
  // advance the model, then check the registered outputs after the edge.
  task automatic step(input logic r, input logic [els_p-1:0] q,
                      input logic [width_p-1:0] lim, input logic e);
    bit exp_x;
    reset_i = r;
    reqs_i  = q;
    limit_i = lim;
    en_i    = e;
    #1;
    exp_x = !r && m_busy && q[m_id] && e && (m_left == 1);
    check("expired_o", expired_o, exp_x);
    if (expired_o === 1'b1) n_expired_seen++;

    if (r) begin
      m_busy = 1'b0;
      m_id   = els_p - 1;
      m_left = 1;
      m_pc   = 0;
    end else if (!m_busy || !q[m_id] || exp_x) begin
      if (exp_x && ((q & ~(4'b0001 << m_id)) != '0) && m_pc != 16'hFFFF)
        m_pc++;
      if (q != '0) begin
        m_busy = 1'b1;
        m_id   = model_pick(q, m_id);
        m_left = (lim == '0) ? 1 : int'(lim);
      end else begin
        m_busy = 1'b0;
      end
    end else if (e) begin
      m_left--;
    end

    @(posedge clk_i);
    #1;
    check("grants_o", grants_o, m_busy ? (32'd1 << m_id) : 32'd0);
    check("grant_id_o", grant_id_o, m_id);
    check("busy_o", busy_o, m_busy);
`ifdef BSG_TIMESLICE_ARB_PREEMPT_STATS_EN
    check("preempt_count_o", preempt_count_o, m_pc);
`endif
    @(negedge clk_i);
  endtask

  initial begin
    int n_g0;
    logic [els_p-1:0] rq;
    @(negedge clk_i);

    // Reset values
    step(1'b1, 4'b0000, 16'd0, 1'b0);
    step(1'b1, 4'b0000, 16'd0, 1'b0);
    check("reset_grants", grants_o, 32'h0);
    check("reset_grant_id", grant_id_o, 32'd3);

    // Two requesters, limit 3: 0001 x3, 0100 x3, 0001 again
    n_expired_seen = 0;
    for (int i = 0; i < 7; i++) begin
      step(1'b0, 4'b0101, 16'd3, 1'b1);
      if (i == 0) check("rr_first_grant", grants_o, 32'b0001);
      if (i == 3) check("rr_second_grant", grants_o, 32'b0100);
    end
    check("rr_back_to_0", grants_o, 32'b0001);
    check("rr_expiry_count", n_expired_seen, 32'd2);

    // Single requester, limit 2: continuous grant, pulse every 2nd cycle
    step(1'b1, 4'b0000, 16'd0, 1'b0);
    n_expired_seen = 0;
    for (int i = 0; i < 9; i++) begin
      step(1'b0, 4'b0010, 16'd2, 1'b1);
      check("single_no_bubble", grants_o, 32'b0010);
    end
    check("single_expiry_count", n_expired_seen, 32'd4);

    // Enable gating: 4 enabled + 5 disabled cycles before the grant moves
    step(1'b1, 4'b0000, 16'd0, 1'b0);
    n_g0 = 0;
    step(1'b0, 4'b0011, 16'd4, 1'b1);
    if (grants_o === 4'b0001) n_g0++;
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 4'b0011, 16'd4, (i == 0 || i >= 6));
      if (grants_o === 4'b0001) n_g0++;
    end
    check("en_gating_len", n_g0, 32'd9);
    check("en_gating_next", grants_o, 32'b0010);

    // Early release with a long slice
    step(1'b1, 4'b0000, 16'd0, 1'b0);
    n_expired_seen = 0;
    step(1'b0, 4'b0011, 16'd10, 1'b1);
    step(1'b0, 4'b0011, 16'd10, 1'b1);
    step(1'b0, 4'b0010, 16'd10, 1'b1);
    check("early_release_grant", grants_o, 32'b0010);
    check("early_release_no_pulse", n_expired_seen, 32'd0);

    // limit 0 behaves as 1: grant alternates every cycle
    step(1'b1, 4'b0000, 16'd0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 4'b0011, 16'd0, 1'b1);
    check("limit0_alternate", grants_o, 32'b0010);

    // limit change mid-slice is ignored
    step(1'b1, 4'b0000, 16'd0, 1'b0);
    step(1'b0, 4'b0011, 16'd3, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 4'b0011, 16'd7, 1'b1);
    check("limit_change_ignored", grants_o, 32'b0010);

    // Reset mid-slice, then requester 0 wins first
    step(1'b0, 4'b1100, 16'd10, 1'b1);
    step(1'b0, 4'b1100, 16'd10, 1'b1);
    step(1'b1, 4'b1100, 16'd10, 1'b1);
    check("reset_mid_slice", grants_o, 32'h0);
    step(1'b0, 4'b1111, 16'd10, 1'b1);
    check("post_reset_first", grants_o, 32'b0001);

`ifdef BSG_TIMESLICE_ARB_PREEMPT_STATS_EN
    step(1'b1, 4'b0000, 16'd0, 1'b0);
    step(1'b0, 4'b0011, 16'd2, 1'b1);
    for (int i = 0; i < 10; i++) step(1'b0, 4'b0011, 16'd2, 1'b1);
    check("preempt_count_10", preempt_count_o, 32'd5);
`endif

    // Randomized phase
    for (int i = 0; i < 500; i++) begin
      rq = 4'($urandom);
      if ($urandom_range(0, 3) == 0) rq = '0;
      step($urandom_range(0, 49) == 0, rq, 16'($urandom_range(0, 5)),
           $urandom_range(0, 3) != 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
